// File: rtl/lf_mode_sequencer_if.sv
// SPI link from the ARM into the LF mode sequencer. All three lines are
// asynchronous to pck0 and are synchronized inside the sequencer.
interface lf_mode_sequencer_if;
  logic spck;
  logic mosi;
  logic ncs;

  modport master (output spck, output mosi, output ncs);
  modport slave  (input  spck, input  mosi, input  ncs);
endinterface

// File: rtl/lf_mode_sequencer.sv
// LF mode sequencer: receives 16-bit SPI command frames and applies mode,
// divisor and threshold settings, inserting an OFF guard window between modes.
module lf_mode_sequencer #(
  parameter int unsigned GUARD_CYCLES = 16,
  parameter logic [7:0]  DIV_RESET    = 8'd95
) (
  input  logic                pck0,
  input  logic                nreset,
  lf_mode_sequencer_if.slave  spi,
  output logic [2:0]          major_mode,
  output logic                lf_field,
  output logic                lf_ed_toggle_mode,
  output logic [7:0]          divisor,
  output logic [7:0]          lf_ed_threshold,
  output logic                mode_quiet,
  output logic                cmd_strobe,
  output logic                frame_err
);

  localparam logic [7:0] GUARD_LAST = 8'(GUARD_CYCLES - 1);
  localparam logic [2:0] MODE_OFF   = 3'b111;
  localparam logic [2:0] MODE_ED    = 3'b001;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GUARD = 1'b1
  } state_t;

  logic [1:0]  r_spck_s;
  logic [1:0]  r_mosi_s;
  logic [1:0]  r_ncs_s;
  logic        r_spck_d;
  logic        r_ncs_d;
  logic [15:0] r_shift;
  logic [4:0]  r_bit_cnt;
  logic        r_acc_vld;
  logic [3:0]  r_acc_cmd;
  logic [8:0]  r_acc_data;
  logic        r_frame_err;
  logic        r_cmd_strobe;
  logic [7:0]  r_divisor;
  logic [7:0]  r_threshold;

  state_t      r_state;
  logic [2:0]  r_major;
  logic        r_field;
  logic        r_toggle;
  logic        r_quiet;
  logic [7:0]  r_gcnt;
  logic [2:0]  r_pmode;
  logic [1:0]  r_popt;

  state_t      w_state_nxt;
  logic [2:0]  w_major_nxt;
  logic        w_field_nxt;
  logic        w_toggle_nxt;
  logic        w_quiet_nxt;
  logic [7:0]  w_gcnt_nxt;
  logic [2:0]  w_pmode_nxt;
  logic [1:0]  w_popt_nxt;

  logic        w_spck_rise;
  logic        w_ncs_low;
  logic        w_ncs_fall;
  logic        w_ncs_rise;
  logic        w_is_cmd1;
  logic        w_is_cmd2;
  logic        w_is_cmd3;
  logic [2:0]  w_new_mode;
  logic [1:0]  w_new_opt;

  assign w_spck_rise = r_spck_s[1] & ~r_spck_d;
  assign w_ncs_low   = ~r_ncs_s[1];
  assign w_ncs_fall  = ~r_ncs_s[1] & r_ncs_d;
  assign w_ncs_rise  = r_ncs_s[1] & ~r_ncs_d;

  assign w_is_cmd1  = r_acc_vld && (r_acc_cmd == 4'd1);
  assign w_is_cmd2  = r_acc_vld && (r_acc_cmd == 4'd2);
  assign w_is_cmd3  = r_acc_vld && (r_acc_cmd == 4'd3);
  assign w_new_mode = r_acc_data[8:6];
  assign w_new_opt  = r_acc_data[1:0];

  // Two-flop synchronizers plus one delay stage for edge detection.
  always_ff @(posedge pck0 or negedge nreset) begin
    if (!nreset) begin
      r_spck_s <= 2'b00;
      r_mosi_s <= 2'b00;
      r_ncs_s  <= 2'b11;
      r_spck_d <= 1'b0;
      r_ncs_d  <= 1'b1;
    end else begin
      r_spck_s <= {r_spck_s[0], spi.spck};
      r_mosi_s <= {r_mosi_s[0], spi.mosi};
      r_ncs_s  <= {r_ncs_s[0], spi.ncs};
      r_spck_d <= r_spck_s[1];
      r_ncs_d  <= r_ncs_s[1];
    end
  end

  // Shift register and saturating bit counter; 17 marks an over-long frame.
  always_ff @(posedge pck0 or negedge nreset) begin
    if (!nreset) begin
      r_shift   <= 16'h0000;
      r_bit_cnt <= 5'd0;
    end else if (w_ncs_fall) begin
      r_bit_cnt <= 5'd0;
    end else if (w_spck_rise && w_ncs_low) begin
      r_shift   <= {r_shift[14:0], r_mosi_s[1]};
      r_bit_cnt <= (r_bit_cnt == 5'd17) ? 5'd17 : (r_bit_cnt + 5'd1);
    end else begin
      r_shift   <= r_shift;
      r_bit_cnt <= r_bit_cnt;
    end
  end

  // Frame acceptance stage: latch the command or flag a bad bit count.
  always_ff @(posedge pck0 or negedge nreset) begin
    if (!nreset) begin
      r_acc_vld   <= 1'b0;
      r_acc_cmd   <= 4'd0;
      r_acc_data  <= 9'd0;
      r_frame_err <= 1'b0;
    end else begin
      r_acc_vld   <= w_ncs_rise && (r_bit_cnt == 5'd16);
      r_frame_err <= w_ncs_rise && (r_bit_cnt != 5'd16);
      if (w_ncs_rise && (r_bit_cnt == 5'd16)) begin
        r_acc_cmd  <= r_shift[15:12];
        r_acc_data <= r_shift[8:0];
      end else begin
        r_acc_cmd  <= r_acc_cmd;
        r_acc_data <= r_acc_data;
      end
    end
  end

  // Divisor, threshold and command strobe; these never wait for the guard.
  always_ff @(posedge pck0 or negedge nreset) begin
    if (!nreset) begin
      r_cmd_strobe <= 1'b0;
      r_divisor    <= DIV_RESET;
      r_threshold  <= 8'd127;
    end else begin
      r_cmd_strobe <= w_is_cmd1 || w_is_cmd2 || w_is_cmd3;
      if (w_is_cmd2) begin
        r_divisor <= r_acc_data[7:0];
      end else begin
        r_divisor <= r_divisor;
      end
      if (w_is_cmd3) begin
        r_threshold <= r_acc_data[7:0];
      end else if (w_is_cmd1 && (w_new_mode == MODE_ED)) begin
        r_threshold <= 8'd127;
      end else begin
        r_threshold <= r_threshold;
      end
    end
  end

  // Mode FSM state and applied-mode registers.
  always_ff @(posedge pck0 or negedge nreset) begin
    if (!nreset) begin
      r_state  <= ST_IDLE;
      r_major  <= MODE_OFF;
      r_field  <= 1'b0;
      r_toggle <= 1'b0;
      r_quiet  <= 1'b0;
      r_gcnt   <= 8'd0;
      r_pmode  <= MODE_OFF;
      r_popt   <= 2'b00;
    end else begin
      r_state  <= w_state_nxt;
      r_major  <= w_major_nxt;
      r_field  <= w_field_nxt;
      r_toggle <= w_toggle_nxt;
      r_quiet  <= w_quiet_nxt;
      r_gcnt   <= w_gcnt_nxt;
      r_pmode  <= w_pmode_nxt;
      r_popt   <= w_popt_nxt;
    end
  end

  // Mode FSM next state: a change of mode passes through OFF for the guard time.
  always_comb begin
    w_state_nxt  = r_state;
    w_major_nxt  = r_major;
    w_field_nxt  = r_field;
    w_toggle_nxt = r_toggle;
    w_quiet_nxt  = r_quiet;
    w_gcnt_nxt   = r_gcnt;
    w_pmode_nxt  = r_pmode;
    w_popt_nxt   = r_popt;
    case (r_state)
      ST_IDLE: begin
        if (w_is_cmd1) begin
          w_pmode_nxt = w_new_mode;
          w_popt_nxt  = w_new_opt;
          if ((w_new_mode == r_major) || (w_new_mode == MODE_OFF)) begin
            w_major_nxt  = w_new_mode;
            w_field_nxt  = w_new_opt[0];
            w_toggle_nxt = w_new_opt[1];
          end else begin
            w_major_nxt = MODE_OFF;
            w_quiet_nxt = 1'b1;
            w_gcnt_nxt  = 8'd0;
            w_state_nxt = ST_GUARD;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_GUARD: begin
        if (w_is_cmd1) begin
          w_pmode_nxt = w_new_mode;
          w_popt_nxt  = w_new_opt;
          w_gcnt_nxt  = 8'd0;
        end else if (r_gcnt == GUARD_LAST) begin
          w_major_nxt  = r_pmode;
          w_field_nxt  = r_popt[0];
          w_toggle_nxt = r_popt[1];
          w_quiet_nxt  = 1'b0;
          w_state_nxt  = ST_IDLE;
        end else begin
          w_gcnt_nxt = r_gcnt + 8'd1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign major_mode        = r_major;
  assign lf_field          = r_field;
  assign lf_ed_toggle_mode = r_toggle;
  assign divisor           = r_divisor;
  assign lf_ed_threshold   = r_threshold;
  assign mode_quiet        = r_quiet;
  assign cmd_strobe        = r_cmd_strobe;
  assign frame_err         = r_frame_err;

endmodule

// File: tb/tb_lf_mode_sequencer.sv
// Scoreboard bench for lf_mode_sequencer: SPI frames drive an event-level
// reference model; a monitor compares every strobe/error pulse and guard exit.
module tb_lf_mode_sequencer;

  localparam int         G    = 100;
  localparam logic [7:0] DIVR = 8'd95;

  logic       pck0 = 1'b0;
  logic       nreset = 1'b0;
  logic [2:0] major_mode;
  logic       lf_field;
  logic       lf_ed_toggle_mode;
  logic [7:0] divisor;
  logic [7:0] lf_ed_threshold;
  logic       mode_quiet;
  logic       cmd_strobe;
  logic       frame_err;

  lf_mode_sequencer_if spi_if ();

  lf_mode_sequencer #(.GUARD_CYCLES(G), .DIV_RESET(DIVR)) dut (
    .pck0              (pck0),
    .nreset            (nreset),
    .spi               (spi_if.slave),
    .major_mode        (major_mode),
    .lf_field          (lf_field),
    .lf_ed_toggle_mode (lf_ed_toggle_mode),
    .divisor           (divisor),
    .lf_ed_threshold   (lf_ed_threshold),
    .mode_quiet        (mode_quiet),
    .cmd_strobe        (cmd_strobe),
    .frame_err         (frame_err)
  );

  always #5 pck0 = ~pck0;

  // kind: 1..3 command strobe, 4 frame error
  typedef struct {
    int         kind;
    logic [2:0] mm;
    logic       f;
    logic       t;
    logic [7:0] div;
    logic [7:0] thr;
    logic       q;
  } exp_t;

  typedef struct {
    logic [2:0] mm;
    logic       f;
    logic       t;
  } app_t;

  exp_t exp_q[$];
  app_t app_q[$];

  int checks = 0;
  int errors = 0;

  logic [2:0] m_mm;
  logic       m_f, m_t;
  logic [7:0] m_div, m_thr;
  logic       m_guard, m_fresh;
  logic [2:0] m_pm;
  logic [1:0] m_po;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic model_reset();
    m_mm = 3'b111; m_f = 1'b0; m_t = 1'b0;
    m_div = DIVR; m_thr = 8'd127;
    m_guard = 1'b0; m_fresh = 1'b0; m_pm = 3'b111; m_po = 2'b00;
  endtask

  task automatic check_reset(input string name);
    chk(name, 64'({major_mode, lf_field, lf_ed_toggle_mode, divisor, lf_ed_threshold,
                   mode_quiet, cmd_strobe, frame_err}),
        64'({3'b111, 1'b0, 1'b0, DIVR, 8'd127, 1'b0, 1'b0, 1'b0}));
  endtask

  // Reference behaviour of one complete frame, at the level of whole commands.
  task automatic model_frame(input logic [31:0] bits, input int n);
    exp_t       e;
    logic [3:0] c;
    logic [11:0] d;
    e.kind = 0;
    m_fresh = 1'b0;
    c = bits[15:12];
    d = bits[11:0];
    if (n != 16) begin
      e.kind = 4;
    end else if (c == 4'd1) begin
      e.kind = 1;
      if (d[8:6] == 3'b001) m_thr = 8'd127;
      if (m_guard) begin
        m_pm = d[8:6]; m_po = d[1:0]; m_fresh = 1'b1;
      end else if (d[8:6] == m_mm || d[8:6] == 3'b111) begin
        m_mm = d[8:6]; m_f = d[0]; m_t = d[1];
      end else begin
        m_guard = 1'b1; m_pm = d[8:6]; m_po = d[1:0]; m_fresh = 1'b1;
      end
    end else if (c == 4'd2) begin
      e.kind = 2; m_div = d[7:0];
    end else if (c == 4'd3) begin
      e.kind = 3; m_thr = d[7:0];
    end
    if (e.kind != 0) begin
      e.mm  = m_guard ? 3'b111 : m_mm;
      e.q   = m_guard;
      e.f   = m_f;
      e.t   = m_t;
      e.div = m_div;
      e.thr = m_thr;
      exp_q.push_back(e);
    end
  endtask

  task automatic send_frame(input logic [31:0] bits, input int n);
    @(negedge pck0);
    spi_if.ncs = 1'b0;
    repeat (3) @(negedge pck0);
    for (int i = 0; i < n; i++) begin
      spi_if.mosi = bits[n-1-i];
      repeat (2) @(negedge pck0);
      spi_if.spck = 1'b1;
      repeat (2) @(negedge pck0);
      spi_if.spck = 1'b0;
    end
    repeat (2) @(negedge pck0);
    model_frame(bits, n);
    spi_if.ncs = 1'b1;
    repeat (8) @(negedge pck0);
  endtask

  task automatic settle();
    app_t a;
    if (m_guard) begin
      a.mm = m_pm; a.f = m_po[0]; a.t = m_po[1];
      app_q.push_back(a);
      m_mm = m_pm; m_f = m_po[0]; m_t = m_po[1];
      m_guard = 1'b0;
    end
    repeat (G + 20) @(negedge pck0);
  endtask

  task automatic pulse_reset(input string name);
    @(posedge pck0);
    #2 nreset = 1'b0;
    spi_if.spck = 1'b0;
    spi_if.ncs  = 1'b1;
    repeat (3) @(negedge pck0);
    check_reset(name);
    nreset = 1'b1;
    model_reset();
    repeat (4) @(negedge pck0);
  endtask

  // Monitor: pops the scoreboard on each pulse and checks every guard exit.
  initial begin
    exp_t e;
    app_t a;
    int   since = 0;
    logic prev_q = 1'b0;
    logic hold_bad = 1'b0;
    forever begin
      @(negedge pck0);
      if (!nreset) begin
        prev_q = 1'b0;
        hold_bad = 1'b0;
      end else begin
        if (since < 100000) since++;
        if (cmd_strobe || frame_err) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_pulse: strobe=%0b err=%0b, none expected", cmd_strobe, frame_err);
          end else begin
            e = exp_q.pop_front();
            chk("pulse_kind", 64'({cmd_strobe, frame_err}), (e.kind == 4) ? 64'd1 : 64'd2);
            chk("outs_at_pulse",
                64'({major_mode, lf_field, lf_ed_toggle_mode, divisor, lf_ed_threshold, mode_quiet}),
                64'({e.mm, e.f, e.t, e.div, e.thr, e.q}));
            if (e.kind == 1 && cmd_strobe) since = 0;
          end
        end
        if (!prev_q && mode_quiet) hold_bad = 1'b0;
        if (mode_quiet && major_mode !== 3'b111) hold_bad = 1'b1;
        if (prev_q && !mode_quiet) begin
          if (app_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_guard_exit: mode=%0d, no guard expected", major_mode);
          end else begin
            a = app_q.pop_front();
            chk("guard_len", 64'(since), 64'(G));
            chk("guard_off_hold", 64'(hold_bad), 64'd0);
            chk("applied_mode", 64'({major_mode, lf_field, lf_ed_toggle_mode}), 64'({a.mm, a.f, a.t}));
          end
        end
        prev_q = mode_quiet;
      end
    end
  end

  initial begin
    logic [31:0] rnd;
    logic [31:0] bits;
    logic [2:0]  m;
    int          r, n, c;
    spi_if.spck = 1'b0;
    spi_if.mosi = 1'b0;
    spi_if.ncs  = 1'b1;
    model_reset();
    repeat (3) @(negedge pck0);
    check_reset("reset_state");
    nreset = 1'b1;
    repeat (4) @(negedge pck0);

    send_frame(32'h1000, 16); settle();
    send_frame(32'h2058, 16);
    send_frame(32'h1001, 16);
    send_frame(32'h1043, 16); settle();
    send_frame(32'h3050, 16);
    send_frame(32'h5A5A, 15);
    send_frame(32'hABCDE, 20);
    send_frame(32'h1080, 16);
    send_frame(32'h10C0, 16);
    send_frame(32'h20FF, 16); settle();

    // Reset during the 8th bit of a frame.
    @(negedge pck0);
    spi_if.ncs = 1'b0;
    repeat (3) @(negedge pck0);
    for (int i = 0; i < 8; i++) begin
      spi_if.mosi = i[0];
      repeat (2) @(negedge pck0);
      spi_if.spck = 1'b1;
      if (i < 7) begin
        repeat (2) @(negedge pck0);
        spi_if.spck = 1'b0;
      end
    end
    pulse_reset("reset_mid_frame");

    send_frame(32'h1080, 16);
    repeat (20) @(negedge pck0);
    pulse_reset("reset_mid_guard");
    send_frame(32'h1080, 16); settle();

    for (int k = 0; k < 40; k++) begin
      rnd = $urandom;
      r = $urandom_range(0, 9);
      n = 16;
      if (r <= 3) begin
        case ($urandom_range(0, 4))
          0: m = 3'd0;
          1: m = 3'd1;
          2: m = 3'd2;
          3: m = 3'd3;
          default: m = 3'd7;
        endcase
        bits = 32'({4'h1, rnd[11:9], m, rnd[5:0]});
      end else if (r <= 5) begin
        bits = 32'({4'h2, rnd[11:0]});
      end else if (r == 6) begin
        bits = 32'({4'h3, rnd[11:0]});
      end else if (r == 7) begin
        c = $urandom_range(4, 16);
        if (c == 16) c = 0;
        bits = 32'({c[3:0], rnd[11:0]});
      end else begin
        case ($urandom_range(0, 4))
          0: n = 0;
          1: n = 1;
          2: n = 15;
          3: n = 17;
          default: n = 20;
        endcase
        bits = rnd;
      end
      send_frame(bits, n);
      if (m_guard && !(m_fresh && ($urandom_range(0, 1) == 1))) begin
        settle();
      end else if (!m_guard) begin
        repeat ($urandom_range(0, 5)) @(negedge pck0);
      end
    end
    settle();

    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    chk("guard_queue_drained", 64'(app_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lf_mode_sequencer.md
LF_MODE_SEQUENCER -- requirements
Module: lf_mode_sequencer

Interface
REQ-001 Parameter GUARD_CYCLES, default 16, number of pck0 cycles major_mode is held at OFF (3'b111) between two different modes; legal range 1..255.
REQ-002 Parameter DIV_RESET, default 8'd95, divisor value after reset.
REQ-003 pck0  input  1  sole clock; all logic rising-edge.
REQ-004 nreset  input  1  reset, asynchronous assert, active-low.
REQ-005 spck  input  1  SPI clock from ARM, asynchronous to pck0.
REQ-006 mosi  input  1  SPI data, MSB first.
REQ-007 ncs  input  1  SPI frame select, active-low.
REQ-008 major_mode  output  3  applied major mode: 000 reader, 001 edge detect, 010 passthru, 011 ADC, 111 off.
REQ-009 lf_field  output  1  applied conf_word[0].
REQ-010 lf_ed_toggle_mode  output  1  applied conf_word[1].
REQ-011 divisor  output  8  clock divider value.
REQ-012 lf_ed_threshold  output  8  edge detect threshold.
REQ-013 mode_quiet  output  1  high while in GUARD.
REQ-014 cmd_strobe  output  1  one-cycle pulse per accepted command 1..3.
REQ-015 frame_err  output  1  one-cycle pulse per frame with bit count != 16.

Function
REQ-016 spck, ncs, mosi SHALL each pass a 2-flop synchronizer to pck0; spck rate is limited to pck0/4.
REQ-017 Synchronized ncs falling edge SHALL clear the 5-bit bit counter to 0.
REQ-018 Synchronized spck rising edge while synchronized ncs low SHALL shift synchronized mosi into 16-bit shift_reg LSB, shifting left, and increment bit counter, saturating at 17.
REQ-019 Synchronized ncs rising edge with counter == 16 SHALL accept frame: cmd = shift_reg[15:12], data = shift_reg[11:0].
REQ-020 Synchronized ncs rising edge with counter != 16 SHALL pulse frame_err for one cycle and change no other state.
REQ-021 cmd 1 (SET_CONFREG): pending mode = data[8:6], pending options = data[1:0]; cmd 2 (SET_DIVISOR): divisor = data[7:0]; cmd 3 (SET_THRESHOLD): lf_ed_threshold = data[7:0].
REQ-022 cmd 0 and 4..15 SHALL be ignored: no strobe, no error, no state change.
REQ-023 Accepted cmd 1..3 outputs and cmd_strobe SHALL update on the pck0 edge following frame acceptance (<= 4 pck0 cycles after pin ncs rise).
REQ-024 cmd 1 with data[8:6] == 001 SHALL set lf_ed_threshold to 127 at acceptance.
REQ-025 FSM states IDLE and GUARD.
REQ-026 IDLE, cmd 1, pending mode == major_mode: lf_field/lf_ed_toggle_mode update immediately; stay IDLE.
REQ-027 IDLE, cmd 1, pending mode != major_mode: major_mode := 111, mode_quiet := 1, guard counter := 0, go GUARD.
REQ-028 IDLE, cmd 1 with pending mode 111: major_mode := 111 and options update immediately, no GUARD.
REQ-029 GUARD: guard counter increments each cycle; at count GUARD_CYCLES-1 apply pending mode and options, mode_quiet := 0, go IDLE; major_mode holds 111 for exactly GUARD_CYCLES cycles.
REQ-030 cmd 1 during GUARD SHALL overwrite pending mode/options and restart guard counter at 0.
REQ-031 cmd 2 or 3 during GUARD SHALL update divisor/threshold immediately without affecting guard timing.
REQ-032 lf_field and lf_ed_toggle_mode SHALL stay at prior values until pending mode is applied.

Reset
REQ-033 nreset low SHALL asynchronously force: major_mode 111, lf_field 0, lf_ed_toggle_mode 0, divisor DIV_RESET, lf_ed_threshold 127, mode_quiet 0, cmd_strobe 0, frame_err 0, state IDLE, bit counter 0, guard counter 0, shift_reg 0, synchronizers 0 except ncs sync 1.
REQ-034 Reset asserted mid-frame or mid-GUARD SHALL abandon both; first frame after release is decoded normally.

Verification
REQ-035 Reset, send 0x1000 (reader) -> major_mode 111 for 16 cycles with mode_quiet 1, then 000, mode_quiet 0, one cmd_strobe.
REQ-036 In mode 000 send 0x2058 -> divisor 0x58 next cycle, no quiet; then 0x1001 -> lf_field 1, major_mode stays 000, no GUARD.
REQ-037 Send 0x1043 (edge detect, field, toggle) -> threshold 127 at acceptance; after 16 quiet cycles major_mode 001, lf_field 1, lf_ed_toggle_mode 1; then 0x3050 -> threshold 0x50.
REQ-038 Frame of 15 bits, and frame of 20 bits -> frame_err pulse each, all outputs unchanged, no cmd_strobe.
REQ-039 During GUARD at count 10 send 0x10C0 -> counter restarts, major_mode 111 for 16 further cycles, then 011; 0x20FF inside GUARD -> divisor 0xFF immediately.
REQ-040 Assert nreset during 8th bit and during GUARD -> all outputs at reset values; following 0x1080 (passthru) behaves as REQ-035.
